// File: rtl/hazard_scoreboard.sv
// Per-register pending-write scoreboard beside ID: produces ID/IF stall and
// per-operand forward selects, tracking writers both inside and outside the forward paths.
module hazard_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NFWD = 3,
  parameter int CW   = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ds_valid,
  input  logic                        ds_use_rs,
  input  logic [AW-1:0]               rs_addr,
  input  logic                        ds_use_rt,
  input  logic [AW-1:0]               rt_addr,
  input  logic                        ds_dest_we,
  input  logic [AW-1:0]               ds_dest,
  input  logic                        ds_issue,
  input  logic [NFWD-1:0]             fwd_valid,
  input  logic [NFWD*AW-1:0]          fwd_dest,
  input  logic [NFWD-1:0]             fwd_ready,
  input  logic                        ws_retire,
  input  logic [AW-1:0]               ws_dest,
  input  logic                        flush,
  output logic                        stallD,
  output logic                        stallF,
  output logic [$clog2(NFWD+1)-1:0]   forward_rs,
  output logic [$clog2(NFWD+1)-1:0]   forward_rt,
  output logic                        sb_empty,
  output logic                        sb_underflow
);

  localparam int FSW = $clog2(NFWD+1);
  localparam logic [CW-1:0] PEND_MAX = {CW{1'b1}};

  logic [CW-1:0] pend_q [1:NREG-1];
  logic [CW-1:0] pend_d [1:NREG-1];
  logic          underflow_q, underflow_d;

  logic          inc, dec;
  logic          pend_nz   [NREG];
  logic          pend_full [NREG];
  logic          rs_stall, rt_stall, struct_stall;
  logic [FSW-1:0] rs_fwd, rt_fwd;

  // First matching source, youngest first, decides between forwarding and stalling.
  function automatic void resolve(
    input  logic                busy,
    input  logic [AW-1:0]       addr,
    input  logic [NFWD-1:0]     fv,
    input  logic [NFWD*AW-1:0]  fd,
    input  logic [NFWD-1:0]     fr,
    output logic                stall,
    output logic [FSW-1:0]      fwd
  );
    logic found;
    stall = 1'b0;
    fwd   = '0;
    found = 1'b0;
    if (busy) begin
      stall = 1'b1;
      for (int k = 0; k < NFWD; k++) begin
        if (!found && fv[k] && (fd[k*AW +: AW] == addr)) begin
          found = 1'b1;
          stall = !fr[k];
          fwd   = fr[k] ? FSW'(k + 1) : '0;
        end
      end
    end
  endfunction

  assign inc = ds_issue & ds_dest_we & (ds_dest != '0);
  assign dec = ws_retire & (ws_dest != '0);

  always_comb begin
    pend_nz[0]   = 1'b0;
    pend_full[0] = 1'b0;
    sb_empty     = 1'b1;
    for (int r = 1; r < NREG; r++) begin
      pend_nz[r]   = (pend_q[r] != '0);
      pend_full[r] = (pend_q[r] == PEND_MAX);
      if (pend_nz[r]) sb_empty = 1'b0;
    end
  end

  always_comb begin
    underflow_d = underflow_q;
    for (int r = 1; r < NREG; r++) pend_d[r] = pend_q[r];
    if (flush) begin
      for (int r = 1; r < NREG; r++) pend_d[r] = '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (inc && (ds_dest == AW'(r)) && !(dec && (ws_dest == AW'(r)))) begin
          pend_d[r] = pend_q[r] + 1'b1;
        end else if (dec && (ws_dest == AW'(r)) && !(inc && (ds_dest == AW'(r)))) begin
          if (pend_q[r] == '0) underflow_d = 1'b1;
          else                 pend_d[r]   = pend_q[r] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 1; r < NREG; r++) pend_q[r] <= '0;
      underflow_q <= 1'b0;
    end else begin
      for (int r = 1; r < NREG; r++) pend_q[r] <= pend_d[r];
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    resolve(ds_use_rs & pend_nz[rs_addr], rs_addr, fwd_valid, fwd_dest, fwd_ready,
            rs_stall, rs_fwd);
    resolve(ds_use_rt & pend_nz[rt_addr], rt_addr, fwd_valid, fwd_dest, fwd_ready,
            rt_stall, rt_fwd);
  end

  // A retire to the same register this cycle frees the slot the new writer needs.
  assign struct_stall = ds_dest_we & pend_full[ds_dest] & !(dec & (ws_dest == ds_dest));

  assign stallD       = ds_valid & (rs_stall | rt_stall | struct_stall);
  assign stallF       = stallD;
  assign forward_rs   = ds_valid ? rs_fwd : '0;
  assign forward_rt   = ds_valid ? rt_fwd : '0;
  assign sb_underflow = underflow_q;

endmodule
